// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding scheduler for the 5-stage core: load-use, redirect and
// iterative-divide hazards, E-stage forwarding selects and a stall counter.
module pipe_hazard_ctrl #(
  parameter int DIV_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       D_ra,
  input  logic [4:0]       D_rb,
  input  logic [4:0]       E_ra,
  input  logic [4:0]       E_rb,
  input  logic [4:0]       E_rd,
  input  logic [1:0]       E_result_src,
  input  logic             E_is_div,
  input  logic             E_redirect,
  input  logic [4:0]       M_rd,
  input  logic             M_RegWrite,
  input  logic [4:0]       W_rd,
  input  logic             W_RegWrite,
  input  logic             div_done,
  output logic             F_en,
  output logic             F_D_en,
  output logic             F_D_flush,
  output logic             D_E_en,
  output logic             CTRL_Flush,
  output logic             E_M_en,
  output logic             E_M_bubble,
  output logic [1:0]       fwdA,
  output logic [1:0]       fwdB,
  output logic             div_start,
  output logic [CNT_W-1:0] stall_count,
  output logic             div_timeout
);

  localparam int WAIT_W = (DIV_TIMEOUT > 1) ? $clog2(DIV_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(DIV_TIMEOUT - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_DIV_WAIT = 1'b1} state_t;

  state_t              state_r;
  state_t              state_nxt_s;
  logic [WAIT_W-1:0]   wait_cnt_r;
  logic [WAIT_W-1:0]   wait_nxt_s;
  logic                timeout_set_s;
  logic                load_use_s;

  // M stage is younger than W, so its result takes priority.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rx,
                                         input logic [4:0] m_rd, input logic m_we,
                                         input logic [4:0] w_rd, input logic w_we);
    logic [1:0] sel;
    if (m_we && (m_rd != 5'd0) && (m_rd == rx)) begin
      sel = 2'b10;
    end else if (w_we && (w_rd != 5'd0) && (w_rd == rx)) begin
      sel = 2'b01;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  assign load_use_s = (E_result_src == 2'b01) && (E_rd != 5'd0) &&
                      ((E_rd == D_ra) || (E_rd == D_rb));

  // Next-state and pipeline control outputs.
  always_comb begin
    F_en          = 1'b1;
    F_D_en        = 1'b1;
    F_D_flush     = 1'b0;
    D_E_en        = 1'b1;
    CTRL_Flush    = 1'b0;
    E_M_en        = 1'b1;
    E_M_bubble    = 1'b0;
    div_start     = 1'b0;
    fwdA          = 2'b00;
    fwdB          = 2'b00;
    state_nxt_s   = state_r;
    wait_nxt_s    = wait_cnt_r;
    timeout_set_s = 1'b0;
    if (rst) begin
      state_nxt_s = ST_RUN;
      wait_nxt_s  = {WAIT_W{1'b0}};
    end else begin
      fwdA = fwd_sel(E_ra, M_rd, M_RegWrite, W_rd, W_RegWrite);
      fwdB = fwd_sel(E_rb, M_rd, M_RegWrite, W_rd, W_RegWrite);
      case (state_r)
        ST_RUN: begin
          if (E_is_div) begin
            div_start   = 1'b1;
            F_en        = 1'b0;
            F_D_en      = 1'b0;
            D_E_en      = 1'b0;
            E_M_en      = 1'b0;
            E_M_bubble  = 1'b1;
            state_nxt_s = ST_DIV_WAIT;
            wait_nxt_s  = {WAIT_W{1'b0}};
          end else if (E_redirect) begin
            // D is squashed, so any load-use hazard on it is moot.
            F_D_flush  = 1'b1;
            CTRL_Flush = 1'b1;
          end else if (load_use_s) begin
            F_en       = 1'b0;
            F_D_en     = 1'b0;
            CTRL_Flush = 1'b1;
          end else begin
            state_nxt_s = ST_RUN;
          end
        end
        ST_DIV_WAIT: begin
          if (div_done) begin
            state_nxt_s = ST_RUN;
            wait_nxt_s  = {WAIT_W{1'b0}};
          end else if (wait_cnt_r == WAIT_LAST) begin
            // Abandon the divide: release exactly as if it had completed.
            timeout_set_s = 1'b1;
            state_nxt_s   = ST_RUN;
            wait_nxt_s    = {WAIT_W{1'b0}};
          end else begin
            F_en       = 1'b0;
            F_D_en     = 1'b0;
            D_E_en     = 1'b0;
            E_M_en     = 1'b0;
            E_M_bubble = 1'b1;
            wait_nxt_s = wait_cnt_r + WAIT_W'(1);
          end
        end
        default: begin
          state_nxt_s = ST_RUN;
          wait_nxt_s  = {WAIT_W{1'b0}};
        end
      endcase
    end
  end

  // State, wait counter, stall counter and sticky watchdog flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_RUN;
      wait_cnt_r  <= {WAIT_W{1'b0}};
      stall_count <= {CNT_W{1'b0}};
      div_timeout <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      wait_cnt_r <= wait_nxt_s;
      if (!F_en) begin
        stall_count <= stall_count + CNT_W'(1);
      end else begin
        stall_count <= stall_count;
      end
      if (timeout_set_s) begin
        div_timeout <= 1'b1;
      end else begin
        div_timeout <= div_timeout;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomized bench for pipe_hazard_ctrl against a behavioural hazard model,
// plus directed scenarios with hand-computed expectations.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  D_ra, D_rb, E_ra, E_rb, E_rd, M_rd, W_rd;
  logic [1:0]  E_result_src;
  logic        E_is_div, E_redirect, M_RegWrite, W_RegWrite, div_done;
  logic        F_en, F_D_en, F_D_flush, D_E_en, CTRL_Flush, E_M_en, E_M_bubble;
  logic [1:0]  fwdA, fwdB;
  logic        div_start, div_timeout;
  logic [31:0] stall_count;

  pipe_hazard_ctrl #(.DIV_TIMEOUT(TMO), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .D_ra(D_ra), .D_rb(D_rb), .E_ra(E_ra), .E_rb(E_rb),
    .E_rd(E_rd), .E_result_src(E_result_src), .E_is_div(E_is_div),
    .E_redirect(E_redirect), .M_rd(M_rd), .M_RegWrite(M_RegWrite), .W_rd(W_rd),
    .W_RegWrite(W_RegWrite), .div_done(div_done), .F_en(F_en), .F_D_en(F_D_en),
    .F_D_flush(F_D_flush), .D_E_en(D_E_en), .CTRL_Flush(CTRL_Flush),
    .E_M_en(E_M_en), .E_M_bubble(E_M_bubble), .fwdA(fwdA), .fwdB(fwdB),
    .div_start(div_start), .stall_count(stall_count), .div_timeout(div_timeout)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: dividing flag, 1-based DIV_WAIT cycle number, counters.
  bit          m_valid = 1'b0;
  bit          m_div   = 1'b0;
  int          m_k     = 0;
  logic [31:0] m_stall = 32'd0;
  bit          m_tout  = 1'b0;

  typedef struct packed {
    logic f, fd, fdf, de, cf, em, bub, start;
    logic [1:0] fa, fb;
  } exp_t;

  function automatic logic [1:0] fwd_of(input logic [4:0] rx);
    if (M_RegWrite && M_rd != 5'd0 && M_rd == rx) return 2'd2;
    if (W_RegWrite && W_rd != 5'd0 && W_rd == rx) return 2'd1;
    return 2'd0;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    bit   hold;
    e = '{f: 1'b1, fd: 1'b1, fdf: 1'b0, de: 1'b1, cf: 1'b0, em: 1'b1,
          bub: 1'b0, start: 1'b0, fa: 2'd0, fb: 2'd0};
    if (rst) return e;
    e.fa = fwd_of(E_ra);
    e.fb = fwd_of(E_rb);
    // Pipeline is frozen while dividing unless it finishes or the watchdog fires.
    hold = m_div ? (!div_done && m_k < TMO) : E_is_div;
    if (hold) begin
      e.f = 1'b0; e.fd = 1'b0; e.de = 1'b0; e.em = 1'b0; e.bub = 1'b1;
      e.start = !m_div;
    end else if (!m_div && E_redirect) begin
      e.fdf = 1'b1; e.cf = 1'b1;
    end else if (!m_div && E_result_src == 2'b01 && E_rd != 5'd0 &&
                 (E_rd == D_ra || E_rd == D_rb)) begin
      e.f = 1'b0; e.fd = 1'b0; e.cf = 1'b1;
    end
    return e;
  endfunction

  // Advance the model on every clock.
  always @(posedge clk) begin
    exp_t e;
    e = model_exp();
    if (rst) begin
      m_valid = 1'b1; m_div = 1'b0; m_k = 0; m_stall = 32'd0; m_tout = 1'b0;
    end else begin
      if (!e.f) m_stall = m_stall + 32'd1;
      if (!m_div) begin
        if (E_is_div) begin m_div = 1'b1; m_k = 1; end
      end else if (div_done) begin
        m_div = 1'b0;
      end else if (m_k == TMO) begin
        m_div = 1'b0; m_tout = 1'b1;
      end else begin
        m_k++;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (m_valid) begin
      e = model_exp();
      chk("F_en", F_en, e.f);
      chk("F_D_en", F_D_en, e.fd);
      chk("F_D_flush", F_D_flush, e.fdf);
      chk("D_E_en", D_E_en, e.de);
      chk("CTRL_Flush", CTRL_Flush, e.cf);
      chk("E_M_en", E_M_en, e.em);
      chk("E_M_bubble", E_M_bubble, e.bub);
      chk("div_start", div_start, e.start);
      chk("fwdA", fwdA, e.fa);
      chk("fwdB", fwdB, e.fb);
      chk("stall_count", stall_count, m_stall);
      chk("div_timeout", div_timeout, m_tout);
    end
  end

  task automatic idle();
    rst = 1'b0; D_ra = 5'd0; D_rb = 5'd0; E_ra = 5'd0; E_rb = 5'd0; E_rd = 5'd0;
    E_result_src = 2'b00; E_is_div = 1'b0; E_redirect = 1'b0; M_rd = 5'd0;
    M_RegWrite = 1'b0; W_rd = 5'd0; W_RegWrite = 1'b0; div_done = 1'b0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1; E_is_div = 1'b1; E_ra = 5'd7; M_rd = 5'd7; M_RegWrite = 1'b1;
    nxt(); nxt(); #2;
    chk("rst_F_en", F_en, 1'b1);
    chk("rst_div_start", div_start, 1'b0);
    chk("rst_fwdA", fwdA, 2'd0);
    chk("rst_stall", stall_count, 32'd0);

    // Load-use stall, then the same pattern with E_rd = x0.
    nxt(); idle(); E_result_src = 2'b01; E_rd = 5'd5; D_ra = 5'd5; #2;
    chk("lu_F_en", F_en, 1'b0);
    chk("lu_ctrl_flush", CTRL_Flush, 1'b1);
    chk("lu_E_M_en", E_M_en, 1'b1);
    nxt(); idle(); #2;
    chk("lu_after_F_en", F_en, 1'b1);
    chk("lu_after_stall", stall_count, 32'd1);
    nxt(); E_result_src = 2'b01; E_rd = 5'd0; D_ra = 5'd0; #2;
    chk("lu_x0_F_en", F_en, 1'b1);

    // Divide finishing in the 5th wait cycle.
    nxt(); idle(); E_is_div = 1'b1; #2;
    chk("div_start_entry", div_start, 1'b1);
    chk("div_entry_de", D_E_en, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      nxt(); #2;
      chk("div_wait_start", div_start, 1'b0);
      chk("div_wait_bubble", E_M_bubble, 1'b1);
    end
    nxt(); div_done = 1'b1; #2;
    chk("div_done_de", D_E_en, 1'b1);
    chk("div_done_bubble", E_M_bubble, 1'b0);
    nxt(); idle(); #2;
    chk("div_stall", stall_count, 32'd6);

    // Redirect beats load-use.
    nxt(); E_redirect = 1'b1; E_result_src = 2'b01; E_rd = 5'd3; D_rb = 5'd3; #2;
    chk("redir_F_en", F_en, 1'b1);
    chk("redir_fd_flush", F_D_flush, 1'b1);
    nxt(); idle(); #2;
    chk("redir_stall", stall_count, 32'd6);

    // Forwarding priority, A and B independently.
    E_ra = 5'd7; M_rd = 5'd7; W_rd = 5'd7; M_RegWrite = 1'b1; W_RegWrite = 1'b1; #1;
    chk("fwdA_M", fwdA, 2'd2);
    M_RegWrite = 1'b0; #1;
    chk("fwdA_W", fwdA, 2'd1);
    E_ra = 5'd0; M_rd = 5'd0; W_rd = 5'd0; M_RegWrite = 1'b1; #1;
    chk("fwdA_x0", fwdA, 2'd0);
    E_rb = 5'd9; M_rd = 5'd9; #1;
    chk("fwdB_M", fwdB, 2'd2);
    chk("fwdA_indep", fwdA, 2'd0);

    // Watchdog: no div_done for TMO wait cycles.
    nxt(); idle(); E_is_div = 1'b1;
    for (int i = 1; i < TMO; i++) begin
      nxt(); #2;
      chk("tmo_hold", F_en, 1'b0);
    end
    nxt(); #2;
    chk("tmo_release", F_en, 1'b1);
    nxt(); idle(); #2;
    chk("tmo_flag", div_timeout, 1'b1);
    chk("tmo_stall", stall_count, 32'd14);
    nxt(); E_result_src = 2'b01; E_rd = 5'd4; D_rb = 5'd4;
    nxt(); idle(); nxt(); #2;
    chk("tmo_sticky", div_timeout, 1'b1);

    // Random traffic, model-checked every cycle.
    for (int c = 0; c < 3000; c++) begin
      nxt();
      rst          = ($urandom_range(0, 249) == 0);
      D_ra         = 5'($urandom_range(0, 7));
      D_rb         = 5'($urandom_range(0, 7));
      E_ra         = 5'($urandom_range(0, 7));
      E_rb         = 5'($urandom_range(0, 7));
      E_rd         = 5'($urandom_range(0, 7));
      M_rd         = 5'($urandom_range(0, 7));
      W_rd         = 5'($urandom_range(0, 7));
      E_result_src = 2'($urandom_range(0, 3));
      E_is_div     = ($urandom_range(0, 9) == 0);
      E_redirect   = ($urandom_range(0, 7) == 0);
      div_done     = ($urandom_range(0, 5) == 0);
      M_RegWrite   = 1'($urandom_range(0, 1));
      W_RegWrite   = 1'($urandom_range(0, 1));
    end

    // Reset in the 3rd DIV_WAIT cycle.
    nxt(); idle(); rst = 1'b1;
    nxt(); idle();
    nxt(); E_is_div = 1'b1;
    nxt(); nxt();
    nxt(); rst = 1'b1; #2;
    chk("rstdiv_F_en", F_en, 1'b1);
    chk("rstdiv_start", div_start, 1'b0);
    nxt(); idle(); #2;
    chk("rstdiv_stall", stall_count, 32'd0);
    chk("rstdiv_de", D_E_en, 1'b1);
    chk("rstdiv_tmo", div_timeout, 1'b0);
    nxt(); nxt();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
